i2c_target_responder: RTL and testbench
=======================================

Name: i2c_target_responder

Overview:
- I2C target (slave) that answers the team's I2C transmit/read master. It emulates an ADT7420-style pointer-plus-register-file device on the same SCL/SDA pair.
- Used on-board as a loopback target for bring-up and ILA capture, and in simulation as the bus-side model for the master.
- Oversamples SCL/SDA on the system clock. SDA is driven only as open-drain (pull-low enable). SCL is never stretched.

Parameters:
- I2C_ADDR, 7'h48, 7-bit target address matched after START.
- REG_COUNT, 16, number of 8-bit registers; must be a power of 2, 2..256.
- PTR_W, $clog2(REG_COUNT), pointer width (derived, not overridden).

Ports:
- sys_clk  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  asynchronous, active-high reset.
- scl_in  input  1  raw SCL from pad.
- sda_in  input  1  raw SDA from pad.
- sda_drive_low  output  1  1 = pull SDA low; 0 = release (high-Z).
- loc_wr_en  input  1  local-side register write strobe.
- loc_wr_addr  input  PTR_W  local write address.
- loc_wr_data  input  8  local write data, e.g. a temperature sample.
- bus_wr_strobe  output  1  one-cycle pulse when an I2C master write commits a byte.
- bus_wr_addr  output  PTR_W  register written by the master, valid with the strobe.
- bus_wr_data  output  8  byte written by the master, valid with the strobe.
- State  output  4  current FSM state encoding, for ILA.
- ACK_bit  output  6  count of ACKs this target has driven, wrapping at 63.
- busy  output  1  high from an addressed START until STOP or NACK-idle.

Behaviour:
- Reset values: sda_drive_low=0, State=IDLE, ACK_bit=0, busy=0, bus_wr_strobe=0, pointer=0, all registers=8'h00.
- Reset asserted mid-transfer releases SDA within the same cycle.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer, then a 1-flop edge detector.
  - Bus-event latency is 3 sys_clk cycles.
- Bus events, evaluated on synced values:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data is sampled on the SCL rising edge. Drive changes only on the SCL falling edge.
- START in any state, including repeated START: go to ADDR, clear the bit counter, release SDA.
- STOP in any state: go to IDLE, release SDA, busy=0. The pointer is retained.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first; bit 0 is R/W. On the falling edge after bit 8:
    - Address match: drive ACK and go to ADDR_ACK.
    - Mismatch: go to IDLE with no ACK; ignore the bus until the next START.
  - ADDR_ACK: release SDA on the next falling edge.
    - R/W=0: go to PTR.
    - R/W=1: go to RDATA and drive bit 7 of reg[pointer] at that same falling edge.
  - PTR: shift 8 bits, always ACK, pointer <= byte[PTR_W-1:0] (upper bits ignored). Then go to PTR_ACK, then WDATA.
  - WDATA: shift 8 bits, then ACK.
    - Commit reg[pointer] <= byte and pulse bus_wr_strobe on the cycle of the 8th rising edge.
    - Pointer increments with wrap: REG_COUNT-1 -> 0.
    - Go to WDATA_ACK, then back to WDATA.
  - RDATA: shift out 8 bits of reg[pointer]. A 0 bit means pull low; a 1 bit means release. Release SDA after the 8th bit to go to RDATA_ACK.
  - RDATA_ACK: sample the master's bit on the rising edge; pointer increments with wrap.
    - ACK (0): load reg[pointer] and continue in RDATA.
    - NACK (1): go to IDLE and wait for STOP or START.
- Read data is captured into a shift register at byte start. A later local write does not corrupt the byte in flight.
- ACK_bit increments once per target-driven ACK: address, pointer, and data.
- Write conflict: a bus commit and loc_wr_en to the same address in the same cycle -> the bus write wins. Local writes otherwise always succeed.
- STOP or START mid-byte: the partial byte is discarded, with no commit and no pointer change.
- busy=1 from the ADDR_ACK entry until IDLE.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK), 4-bit;
  - default address constant ADT7420_ADDR=7'h48;
  - sync depth constant.
- One sub-module: i2c_line_sync. It covers the 2-flop sync and edge detect for SCL and SDA, and outputs scl_rise, scl_fall, start_det and stop_det.
- The FSM and register file stay in the top module.

Test Plan:
- Local write reg0=8'hAB, reg1=8'hCD; master: START, 0x90, ptr 0x00, Sr, 0x91, read 2 bytes with ACK then NACK, STOP -> reads 0xAB then 0xCD; ACK_bit=3; busy low after STOP.
- Master: START, 0x90, ptr 0x0F, data 0x11, 0x22, STOP -> reg15=0x11, reg0=0x22 (wrap); two bus_wr_strobe pulses with addr 15 then 0.
- START, 0x92 (wrong address) -> SDA never pulled low; State returns to IDLE; ACK_bit unchanged.
- START, 0x90, ptr 0x03, 4 data bits then STOP -> reg3 unchanged; no strobe; SDA released; State=IDLE.
- reset pulsed while the target is driving a 0 read bit -> sda_drive_low=0 within 1 cycle; all outputs at reset values; next transaction succeeds.
- Same-cycle loc_wr_en and bus commit to reg2 (local 0x55, bus 0x77) -> reg2=0x77.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder and its line conditioner.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } i2c_state_e;

  localparam logic [6:0] ADT7420_ADDR = 7'h48;
  localparam int         SYNC_STAGES  = 2;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA into sys_clk and derives SCL edges plus START/STOP events.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Reset to the idle-bus level so releasing reset never looks like a START.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign sda_o       = sda_s;
  assign scl_rise_o  = scl_s & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s & scl_prev_q;
  assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// ADT7420-style I2C target: address match, register pointer, and auto-incrementing
// register-file reads/writes over an open-drain SDA, with a local write port.
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR  = ADT7420_ADDR,
  parameter int         REG_COUNT = 16,
  parameter int         PTR_W     = $clog2(REG_COUNT)
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_drive_low,
  input  logic             loc_wr_en,
  input  logic [PTR_W-1:0] loc_wr_addr,
  input  logic [7:0]       loc_wr_data,
  output logic             bus_wr_strobe,
  output logic [PTR_W-1:0] bus_wr_addr,
  output logic [7:0]       bus_wr_data,
  output logic [3:0]       State,
  output logic [5:0]       ACK_bit,
  output logic             busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk_i       (sys_clk),
    .rst_i       (reset),
    .scl_i       (scl_in),
    .sda_i       (sda_in),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  i2c_state_e       state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       tx_q, tx_d;
  logic             sda_q, sda_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [5:0]       ack_cnt_q, ack_cnt_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;
  logic             mack_q, mack_d;
  logic             commit;
  logic [7:0]       wr_byte;
  logic [7:0]       regs_q [REG_COUNT];

  assign wr_byte = {shift_q[6:0], sda_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    sda_d     = sda_q;
    ptr_d     = ptr_q;
    ack_cnt_d = ack_cnt_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    mack_d    = mack_q;
    commit    = 1'b0;
    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_d     = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      sda_d     = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = wr_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            // The 8th data bit commits immediately, before the ACK slot.
            if (state_q == ST_WDATA && bit_cnt_q == 4'd7) begin
              commit = 1'b1;
              ptr_d  = ptr_q + 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            case (state_q)
              ST_ADDR: begin
                if (shift_q[7:1] == I2C_ADDR) begin
                  sda_d     = 1'b1;
                  ack_cnt_d = ack_cnt_q + 6'd1;
                  rw_d      = shift_q[0];
                  busy_d    = 1'b1;
                  state_d   = ST_ADDR_ACK;
                end else begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
                end
              end
              ST_PTR: begin
                sda_d     = 1'b1;
                ack_cnt_d = ack_cnt_q + 6'd1;
                ptr_d     = shift_q[PTR_W-1:0];
                state_d   = ST_PTR_ACK;
              end
              default: begin
                sda_d     = 1'b1;
                ack_cnt_d = ack_cnt_q + 6'd1;
                state_d   = ST_WDATA_ACK;
              end
            endcase
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              tx_d    = regs_q[ptr_q];
              sda_d   = ~regs_q[ptr_q][7];
              state_d = ST_RDATA;
            end else begin
              sda_d   = 1'b0;
              state_d = ST_PTR;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_d     = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_WDATA;
          end
        end
        ST_RDATA: begin
          // tx_q[7] is always the bit currently on the wire.
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            if (bit_cnt_q == 4'd8) begin
              sda_d   = 1'b0;
              state_d = ST_RDATA_ACK;
            end else begin
              tx_d  = {tx_q[6:0], 1'b0};
              sda_d = ~tx_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            mack_d = sda_s;
            ptr_d  = ptr_q + 1'b1;
          end else if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (!mack_q) begin
              tx_d    = regs_q[ptr_q];
              sda_d   = ~regs_q[ptr_q][7];
              state_d = ST_RDATA;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      tx_q      <= 8'h00;
      sda_q     <= 1'b0;
      ptr_q     <= '0;
      ack_cnt_q <= 6'd0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      sda_q     <= sda_d;
      ptr_q     <= ptr_d;
      ack_cnt_q <= ack_cnt_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
    end
  end

  // Bus write is applied after the local write so it wins a same-address collision.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
    end else begin
      if (loc_wr_en) regs_q[loc_wr_addr] <= loc_wr_data;
      if (commit)    regs_q[ptr_q]       <= wr_byte;
    end
  end

  // bus_wr_strobe is a valid-only pulse (no ready): addr/data are meaningful only while it is high.
  assign bus_wr_strobe = commit;
  assign bus_wr_addr   = ptr_q;
  assign bus_wr_data   = wr_byte;
  assign sda_drive_low = sda_q;
  assign State         = state_q;
  assign ACK_bit       = ack_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench: bit-banged I2C master on a wired-AND SDA, transaction-level register model,
// and queue-based scoreboards for bus writes and read bytes.
module tb_i2c_target_responder;
  import i2c_pkg::*;

  localparam int         RC   = 16;
  localparam int         PW   = 4;
  localparam int         WW   = PW + 8;
  localparam int         Q    = 5;
  localparam logic [6:0] TADR = 7'h48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_bus;
  logic          sda_drive_low;
  logic          loc_wr_en = 1'b0;
  logic [PW-1:0] loc_wr_addr = '0;
  logic [7:0]    loc_wr_data = 8'h00;
  logic          bus_wr_strobe;
  logic [PW-1:0] bus_wr_addr;
  logic [7:0]    bus_wr_data;
  logic [3:0]    state_dbg;
  logic [5:0]    ack_bit;
  logic          busy;

  assign sda_bus = sda_m & ~sda_drive_low;

  i2c_target_responder #(.I2C_ADDR(TADR), .REG_COUNT(RC)) dut (
    .sys_clk       (clk),
    .reset         (rst),
    .scl_in        (scl),
    .sda_in        (sda_bus),
    .sda_drive_low (sda_drive_low),
    .loc_wr_en     (loc_wr_en),
    .loc_wr_addr   (loc_wr_addr),
    .loc_wr_data   (loc_wr_data),
    .bus_wr_strobe (bus_wr_strobe),
    .bus_wr_addr   (bus_wr_addr),
    .bus_wr_data   (bus_wr_data),
    .State         (state_dbg),
    .ACK_bit       (ack_bit),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] wr_exp_q[$];
  logic [7:0]    rd_exp_q[$];
  logic [7:0]    tx_bytes[$];

  logic [7:0] m_regs[RC];
  int         m_ptr;
  int         m_ack;

  logic       rd_valid = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  logic       watch_low = 1'b0;
  int         low_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin : wr_mon
    logic [WW-1:0] e;
    if (bus_wr_strobe) begin
      if (wr_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_wr_unexpected actual=%0h expected=none", {bus_wr_addr, bus_wr_data});
      end else begin
        e = wr_exp_q.pop_front();
        check("bus_wr", 32'({bus_wr_addr, bus_wr_data}), 32'(e));
      end
    end
    if (watch_low && sda_drive_low) low_seen++;
  end

  always @(posedge clk) begin : rd_mon
    logic [7:0] e;
    if (rd_valid) begin
      if (rd_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%0h expected=none", rd_byte);
      end else begin
        e = rd_exp_q.pop_front();
        check("rd_byte", 32'(rd_byte), 32'(e));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Bus driver tasks
  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b0; wq();
    scl = 1'b0;   wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wq();
    scl = 1'b1; wq(); wq();
    scl = 1'b0; wq();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    b = sda_bus; wq();
    scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic loc_write(input logic [PW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_wr_en = 1'b1; loc_wr_addr = a; loc_wr_data = d;
    @(negedge clk);
    loc_wr_en = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < RC; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    m_ack = 0;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sda"}, 32'(sda_drive_low), 32'd0);
    check({tag, "_ackcnt"}, 32'(ack_bit), 32'(m_ack % 64));
  endtask

  // Write transaction: pointer byte then tx_bytes, each committed at the next pointer.
  task automatic do_write(input logic [7:0] p);
    logic ack;
    i2c_start();
    write_byte({TADR, 1'b0}, ack); check("w_addr_ack", 32'(ack), 32'd0); m_ack++;
    write_byte(p, ack);            check("w_ptr_ack", 32'(ack), 32'd0);  m_ack++;
    check("w_busy", 32'(busy), 32'd1);
    m_ptr = int'(p) % RC;
    foreach (tx_bytes[i]) begin
      wr_exp_q.push_back({PW'(m_ptr), tx_bytes[i]});
      m_regs[m_ptr] = tx_bytes[i];
      m_ptr = (m_ptr + 1) % RC;
      write_byte(tx_bytes[i], ack); check("w_data_ack", 32'(ack), 32'd0); m_ack++;
    end
    i2c_stop();
    idle_checks("w_end");
  endtask

  // Read transaction: optional pointer set + repeated START, n bytes, last one NACKed.
  task automatic do_read(input int n, input logic set_ptr, input logic [7:0] p);
    logic ack;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      write_byte({TADR, 1'b0}, ack); check("r_addrw_ack", 32'(ack), 32'd0); m_ack++;
      write_byte(p, ack);            check("r_ptr_ack", 32'(ack), 32'd0);   m_ack++;
      m_ptr = int'(p) % RC;
      i2c_start();
    end
    write_byte({TADR, 1'b1}, ack); check("r_addrr_ack", 32'(ack), 32'd0); m_ack++;
    for (int i = 0; i < n; i++) begin
      rd_exp_q.push_back(m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % RC;
      read_byte(d, (i == n - 1));
      rd_byte = d; rd_valid = 1'b1;
      @(negedge clk);
      rd_valid = 1'b0;
    end
    i2c_stop();
    idle_checks("r_end");
  endtask

  initial begin : main
    logic ack;
    logic hit;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_sda", 32'(sda_drive_low), 32'd0);
    check("rst_ackcnt", 32'(ack_bit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobe", 32'(bus_wr_strobe), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Pointer set, repeated START, two-byte read
    loc_write(4'd0, 8'hAB);
    loc_write(4'd1, 8'hCD);
    do_read(2, 1'b1, 8'h00);
    check("tp1_ackcnt", 32'(ack_bit), 32'd3);

    // Write with pointer wrap 15 -> 0, then read back across the wrap
    tx_bytes = '{8'h11, 8'h22};
    do_write(8'h0F);
    do_read(2, 1'b1, 8'h0F);

    // Wrong address: no ACK, bus ignored until next START
    watch_low = 1'b1;
    i2c_start();
    write_byte(8'h92, ack);
    check("mis_nack", 32'(ack), 32'd1);
    check("mis_state", 32'(state_dbg), 32'(ST_IDLE));
    write_byte({TADR, 1'b0}, ack);
    check("mis_ignored", 32'(ack), 32'd1);
    i2c_stop();
    watch_low = 1'b0;
    check("mis_no_drive", 32'(low_seen), 32'd0);
    idle_checks("mis_end");

    // Partial byte aborted by STOP: no commit, pointer stays at 3
    loc_write(4'd3, 8'h5A);
    i2c_start();
    write_byte({TADR, 1'b0}, ack); check("pa_addr_ack", 32'(ack), 32'd0); m_ack++;
    write_byte(8'h03, ack);        check("pa_ptr_ack", 32'(ack), 32'd0);  m_ack++;
    m_ptr = 3;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    i2c_stop();
    idle_checks("pa_end");
    do_read(1, 1'b0, 8'h00);

    // Same-cycle local and bus write to reg2: bus wins
    tx_bytes = '{8'h77};
    hit = 1'b0;
    fork
      do_write(8'h02);
      begin
        for (int c = 0; c < 2000 && !hit; c++) begin
          @(negedge clk);
          if (bus_wr_strobe) begin
            loc_wr_en = 1'b1; loc_wr_addr = 4'd2; loc_wr_data = 8'h55;
            @(negedge clk);
            loc_wr_en = 1'b0;
            hit = 1'b1;
          end
        end
      end
    join
    check("cf_strobe_seen", 32'(hit), 32'd1);
    do_read(1, 1'b1, 8'h02);

    // Reset while the target drives a 0 read bit
    loc_write(4'd0, 8'h3C);
    i2c_start();
    write_byte({TADR, 1'b0}, ack); check("rs_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h00, ack);        check("rs_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    write_byte({TADR, 1'b1}, ack); check("rs_addrr_ack", 32'(ack), 32'd0);
    check("rs_drive_before", 32'(sda_drive_low), 32'd1);
    rst = 1'b1;
    #1;
    check("rs_release", 32'(sda_drive_low), 32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    check("rs_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rs_ackcnt", 32'(ack_bit), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_strobe", 32'(bus_wr_strobe), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    i2c_stop();
    tx_bytes = '{8'hA5};
    do_write(8'h05);
    do_read(2, 1'b1, 8'h04);
    do_read(1, 1'b1, 8'h00);

    // Randomized transactions against the model
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) loc_write(4'($urandom_range(0, RC - 1)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        tx_bytes.delete();
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
        do_write(8'($urandom_range(0, 255)));
      end else begin
        do_read(int'($urandom_range(1, 4)), 1'b1, 8'($urandom_range(0, 255)));
      end
    end

    repeat (10) @(negedge clk);
    check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
